// File: rtl/vector_cache_pkg.sv
// Shared vector-cache definitions: the SRAM instance command format, the raw
// bank read latency, and small sizing helpers used by the SRAM crossbar.
package vector_cache_pkg;

  localparam int VEC_SRAM_ADDR_W = 6;
  localparam int VEC_SRAM_CHAN_W = 4;
  // Raw read latency of one vec_cache_sram_inst bank, in cycles.
  localparam int VEC_SRAM_RD_LAT = 1;

  typedef struct packed {
    logic [VEC_SRAM_CHAN_W-1:0] channel_id;
  } sram_ram_id_t;

  typedef struct packed {
    sram_ram_id_t                 dest_ram_id;
    logic [VEC_SRAM_ADDR_W-1:0]   addr;
  } sram_inst_cmd_t;

  // Index width that stays legal (1 bit) for a single-entry selector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_cache_rr_arb.sv
// Round-robin arbiter: N requests in, one-hot grant plus winner index out.
// The winner is the first requester at or after the pointer (wrapping);
// the pointer moves to winner+1 after a grant and holds when idle.
module vec_cache_rr_arb
  import vector_cache_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           i_req,
  output logic [N-1:0]           o_gnt,
  output logic [idx_width(N)-1:0] o_gnt_idx
);

  localparam int PTR_W = idx_width(N);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             w_found;

  // Pick the winner: first pass covers ports at/after the pointer, second pass wraps.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can leave
    // a value unassigned and imply a latch.
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    for (int p = 0; p < N; p++) begin
      if (!w_found && i_req[p] && (p >= int'(r_ptr))) begin
        o_gnt[p]  = 1'b1;
        o_gnt_idx = PTR_W'(p);
        w_ptr_nxt = (p == N - 1) ? '0 : PTR_W'(p + 1);
        w_found   = 1'b1;
      end
    end
    for (int p = 0; p < N; p++) begin
      if (!w_found && i_req[p]) begin
        o_gnt[p]  = 1'b1;
        o_gnt_idx = PTR_W'(p);
        w_ptr_nxt = (p == N - 1) ? '0 : PTR_W'(p + 1);
        w_found   = 1'b1;
      end
    end
  end

  // Advance the pointer only on a grant.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (rst) begin
      r_ptr <= '0;
    end else if (|i_req) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/vec_cache_sram_inst.sv
// Single vector-cache SRAM bank: one read and one write port, registered read
// data (VEC_SRAM_RD_LAT = 1). A read and write to the same address in the same
// cycle returns the old contents (read-first).
module vec_cache_sram_inst
  import vector_cache_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              read_vld,
  input  sram_inst_cmd_t    read_cmd,
  input  logic              write_vld,
  input  sram_inst_cmd_t    write_cmd,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << VEC_SRAM_ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // The bank id has already been consumed by the crossbar routing.
  logic w_unused_ram_id;
  assign w_unused_ram_id = ^{read_cmd.dest_ram_id, write_cmd.dest_ram_id};

  // Array write and registered read-first read.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; contents are undefined until written,
    // which keeps it mappable onto a real SRAM macro.
    if (write_vld) begin
      r_mem[write_cmd.addr] <= wr_data;
    end
    if (read_vld) begin
      r_rd_data <= r_mem[read_cmd.addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/vec_cache_sram_xbar_group.sv
// Crossbar between NUM_PORT vector-cache requesters and NUM_BANK SRAM banks.
// Bank = low bits of cmd.dest_ram_id.channel_id. Each bank has independent
// round-robin read and write arbiters; read data returns to the issuing port
// after 1 + RD_OUT_REG cycles through a tagged return pipeline.
// Optional: define VEC_CACHE_SRAM_XBAR_PERF_CNT_EN to add per-bank saturating
// conflict counters on perf_conflict_cnt.
module vec_cache_sram_xbar_group
  import vector_cache_pkg::*;
#(
  parameter int NUM_PORT   = 2,
  parameter int NUM_BANK   = 2,
  parameter int DATA_W     = 32,
  parameter int RD_OUT_REG = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_PORT-1:0]                rd_req_vld,
  input  sram_inst_cmd_t [NUM_PORT-1:0]      rd_req_cmd,
  output logic [NUM_PORT-1:0]                rd_req_rdy,
  input  logic [NUM_PORT-1:0]                wr_req_vld,
  input  sram_inst_cmd_t [NUM_PORT-1:0]      wr_req_cmd,
  input  logic [NUM_PORT-1:0][DATA_W-1:0]    wr_req_data,
  output logic [NUM_PORT-1:0]                wr_req_rdy,
  output logic [NUM_PORT-1:0]                rd_rsp_vld,
  output logic [NUM_PORT-1:0][DATA_W-1:0]    rd_rsp_data
`ifdef VEC_CACHE_SRAM_XBAR_PERF_CNT_EN
  ,
  output logic [NUM_BANK-1:0][15:0]          perf_conflict_cnt
`endif
);

  localparam int PORT_W  = idx_width(NUM_PORT);
  localparam int TAG_LAT = VEC_SRAM_RD_LAT;

  typedef struct packed {
    logic              vld;
    logic [PORT_W-1:0] port;
  } xbar_tag_t;

  logic [NUM_BANK-1:0][NUM_PORT-1:0] w_rd_req;
  logic [NUM_BANK-1:0][NUM_PORT-1:0] w_wr_req;
  logic [NUM_BANK-1:0][NUM_PORT-1:0] w_rd_gnt;
  logic [NUM_BANK-1:0][NUM_PORT-1:0] w_wr_gnt;
  logic [PORT_W-1:0]                 w_rd_win [NUM_BANK];
  logic [PORT_W-1:0]                 w_wr_win [NUM_BANK];

  logic [NUM_BANK-1:0]               w_bank_rd_vld;
  logic [NUM_BANK-1:0]               w_bank_wr_vld;
  sram_inst_cmd_t                    w_bank_rd_cmd  [NUM_BANK];
  sram_inst_cmd_t                    w_bank_wr_cmd  [NUM_BANK];
  logic [DATA_W-1:0]                 w_bank_wr_data [NUM_BANK];
  logic [DATA_W-1:0]                 w_bank_rd_data [NUM_BANK];

  xbar_tag_t                         r_tag [TAG_LAT][NUM_BANK];

  logic [NUM_PORT-1:0]               w_rsp_vld;
  logic [NUM_PORT-1:0][DATA_W-1:0]   w_rsp_data;

  // Decode each port's target bank into per-bank request vectors.
  always_comb begin
    w_rd_req = '0;
    w_wr_req = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      for (int p = 0; p < NUM_PORT; p++) begin
        w_rd_req[b][p] = rd_req_vld[p] &&
                         ((int'(rd_req_cmd[p].dest_ram_id.channel_id) % NUM_BANK) == b);
        w_wr_req[b][p] = wr_req_vld[p] &&
                         ((int'(wr_req_cmd[p].dest_ram_id.channel_id) % NUM_BANK) == b);
      end
    end
  end

  // A port is ready when it wins the arbiter of the bank it targets.
  always_comb begin
    rd_req_rdy = '0;
    wr_req_rdy = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      rd_req_rdy = rd_req_rdy | w_rd_gnt[b];
      wr_req_rdy = wr_req_rdy | w_wr_gnt[b];
    end
  end

  for (genvar gb = 0; gb < NUM_BANK; gb++) begin : g_bank
    vec_cache_rr_arb #(.N(NUM_PORT)) u_rd_arb (
      .clk       (clk),
      .rst       (rst),
      .i_req     (w_rd_req[gb]),
      .o_gnt     (w_rd_gnt[gb]),
      .o_gnt_idx (w_rd_win[gb])
    );

    vec_cache_rr_arb #(.N(NUM_PORT)) u_wr_arb (
      .clk       (clk),
      .rst       (rst),
      .i_req     (w_wr_req[gb]),
      .o_gnt     (w_wr_gnt[gb]),
      .o_gnt_idx (w_wr_win[gb])
    );

    // Idle banks see zero commands so the bank inputs never toggle needlessly.
    assign w_bank_rd_vld[gb]  = |w_rd_gnt[gb];
    assign w_bank_wr_vld[gb]  = |w_wr_gnt[gb];
    assign w_bank_rd_cmd[gb]  = w_bank_rd_vld[gb] ? rd_req_cmd[w_rd_win[gb]]  : '0;
    assign w_bank_wr_cmd[gb]  = w_bank_wr_vld[gb] ? wr_req_cmd[w_wr_win[gb]]  : '0;
    assign w_bank_wr_data[gb] = w_bank_wr_vld[gb] ? wr_req_data[w_wr_win[gb]] : '0;

    vec_cache_sram_inst #(.DATA_W(DATA_W)) u_sram (
      .clk       (clk),
      .read_vld  (w_bank_rd_vld[gb]),
      .read_cmd  (w_bank_rd_cmd[gb]),
      .write_vld (w_bank_wr_vld[gb]),
      .write_cmd (w_bank_wr_cmd[gb]),
      .wr_data   (w_bank_wr_data[gb]),
      .rd_data   (w_bank_rd_data[gb])
    );
  end

  // Track which port owns each in-flight bank read, aligned with the bank latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < TAG_LAT; s++) begin
        for (int b = 0; b < NUM_BANK; b++) begin
          r_tag[s][b] <= '0;
        end
      end
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        r_tag[0][b].vld  <= w_bank_rd_vld[b];
        r_tag[0][b].port <= w_rd_win[b];
        for (int s = 1; s < TAG_LAT; s++) begin
          r_tag[s][b] <= r_tag[s-1][b];
        end
      end
    end
  end

  // Steer each returning bank's data to its owning port; a port owns at most one bank.
  always_comb begin
    w_rsp_vld  = '0;
    w_rsp_data = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      if (r_tag[TAG_LAT-1][b].vld) begin
        w_rsp_vld[r_tag[TAG_LAT-1][b].port]  = 1'b1;
        w_rsp_data[r_tag[TAG_LAT-1][b].port] = w_bank_rd_data[b];
      end
    end
  end

  if (RD_OUT_REG != 0) begin : g_out_reg
    logic [NUM_PORT-1:0]             r_rsp_vld;
    logic [NUM_PORT-1:0][DATA_W-1:0] r_rsp_data;

    // Optional output stage trades one cycle of latency for timing margin.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rsp_vld  <= '0;
        r_rsp_data <= '0;
      end else begin
        r_rsp_vld  <= w_rsp_vld;
        r_rsp_data <= w_rsp_data;
      end
    end

    assign rd_rsp_vld  = r_rsp_vld;
    assign rd_rsp_data = r_rsp_data;
  end else begin : g_out_comb
    assign rd_rsp_vld  = w_rsp_vld;
    assign rd_rsp_data = w_rsp_data;
  end

`ifdef VEC_CACHE_SRAM_XBAR_PERF_CNT_EN
  logic [NUM_BANK-1:0]        w_bank_stall;
  logic [NUM_BANK-1:0][15:0]  r_conflict_cnt;

  // A bank stalls when any read or write aimed at it lost arbitration.
  always_comb begin
    w_bank_stall = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      w_bank_stall[b] = (|(w_rd_req[b] & ~w_rd_gnt[b])) |
                        (|(w_wr_req[b] & ~w_wr_gnt[b]));
    end
  end

  // Count stall cycles per bank, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        if (w_bank_stall[b] && (r_conflict_cnt[b] != 16'hFFFF)) begin
          r_conflict_cnt[b] <= r_conflict_cnt[b] + 16'd1;
        end
      end
    end
  end

  assign perf_conflict_cnt = r_conflict_cnt;
`else
  // Conflict counters are not built in this configuration.
`endif

endmodule

// File: doc/vec_cache_sram_xbar_group.md
Name: vec_cache_sram_xbar_group

Overview:
- Parametrised successor to the 2-instance cross-select SRAM pair.
- Routes NUM_PORT independent read and write requesters onto NUM_BANK vec_cache_sram_inst banks; the bank is selected by cmd.dest_ram_id.channel_id.
- Arbitrates bank conflicts round-robin with valid/ready backpressure, instead of treating conflicts as an error.
- Returns read data to the originating port with fixed latency via a tagged return pipeline. Sits between the vector cache datapath and the SRAM instances.

Parameters:
- NUM_PORT, 2, number of requesting ports (≥1).
- NUM_BANK, 2, number of vec_cache_sram_inst banks (power of 2, ≥2).
- DATA_W, 32, data width per bank (must match vec_cache_sram_inst).
- RD_OUT_REG, 0, 1 adds a read-data output register stage: latency 2 instead of 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rd_req_vld  in  NUM_PORT  read request valid per port.
- rd_req_cmd  in  NUM_PORT x sram_inst_cmd_t  read command per port.
- rd_req_rdy  out  NUM_PORT  read request accepted this cycle.
- wr_req_vld  in  NUM_PORT  write request valid per port.
- wr_req_cmd  in  NUM_PORT x sram_inst_cmd_t  write command per port.
- wr_req_data  in  NUM_PORT x DATA_W  write data per port.
- wr_req_rdy  out  NUM_PORT  write request accepted this cycle.
- rd_rsp_vld  out  NUM_PORT  read data valid per port.
- rd_rsp_data  out  NUM_PORT x DATA_W  read data per port.

Behaviour:
- Bank index: low $clog2(NUM_BANK) bits of cmd.dest_ram_id.channel_id. Higher bits are ignored.
- Per bank there are two independent round-robin arbiters, one for read and one for write. A bank accepts at most 1 read and 1 write per cycle; the two may be in the same cycle.
- Arbiter rule: winner = first requesting port at or after ptr, ascending and wrapping. After a grant, ptr = winner+1 mod NUM_PORT. ptr is unchanged when there is no request.
- rdy is combinational:
  - rd_req_rdy[p] = 1 iff port p wins its target bank's read arbiter.
  - rdy with vld low is 0.
  - A transfer occurs on vld & rdy.
  - A requester whose vld is high with rdy low must hold its cmd/data stable until accepted.
- The winning cmd/data drives the bank's read_vld/read_cmd or write_vld/write_cmd/wr_data. Non-granted banks get vld=0, and cmd/data are don't-care (drive 0).
- Return tag: per bank, register {vld, port_id} of the read winner. Pipeline depth = 1 + RD_OUT_REG.
  - rd_rsp_vld[p] is asserted exactly 1+RD_OUT_REG cycles after the read handshake, with rd_rsp_data[p] from that bank.
  - At most one bank returns to a given port per cycle, because a port issues at most 1 read per cycle.
- Read and write to the same bank and same address in the same cycle: ordering is inherited from vec_cache_sram_inst. This block adds no forwarding.
- Reset values:
  - All rr pointers = 0.
  - Tag pipeline valids = 0.
  - rd_rsp_vld = 0; rd_rsp_data = 0.
  - rdy outputs follow the combinational rule (0 when vld is 0).
- Reset mid-operation: in-flight reads are dropped; no rd_rsp_vld in any cycle after rst is sampled high.
- No ordering guarantee across ports. Per port, read responses return in issue order (fixed latency).

Optional Feature:
- Macro: VEC_CACHE_SRAM_XBAR_PERF_CNT_EN.
- When defined:
  - Adds output port perf_conflict_cnt (NUM_BANK x 16).
  - Each counter increments by 1 per cycle in which ≥1 read or write request targeting that bank is not granted (vld & !rdy). Read and write stalls in the same cycle count once.
  - Counters saturate at 16'hFFFF and reset to 0.
- When undefined: the port and counters are absent; functionality is otherwise identical.

Decomposition:
- Shared package vector_cache_pkg provides:
  - sram_inst_cmd_t (existing).
  - New constant VEC_SRAM_RD_LAT = 1 (bank raw latency).
  - Typedef xbar_tag_t {logic vld; logic [$clog2(NUM_PORT)-1:0] port;}. Parameterised by the block; declared as a local typedef if the package cannot carry parameters.
- Sub-module vec_cache_rr_arb: parametrised round-robin arbiter (N requests -> one-hot grant, internal ptr, synchronous active-high reset). It is instantiated 2*NUM_BANK times.

Test Plan (NUM_PORT=4, NUM_BANK=4 unless stated):
1. Each of ports 0..3 reads bank p (no conflict) -> all rd_req_rdy=1; rd_rsp_vld=4'hF exactly 1 cycle later with the previously written data 0xA5A50000+p.
2. Ports 0,1,2 read bank 2 continuously, ptr=0 -> grants port 0,1,2,0,1,2 in successive cycles; each response returns to the matching port; nothing is lost or duplicated.
3. All 4 ports write bank 1 with data 0x11..0x44, then read back -> writes complete over 4 cycles in rr order; final read returns the last-granted data.
4. RD_OUT_REG=1 -> read response appears 2 cycles after the handshake; a read on port 0 and a write on port 1 to the same bank in the same cycle both get rdy=1.
5. rst asserted the cycle after 3 reads are accepted -> no rd_rsp_vld afterwards; rr pointers restart at port 0.
6. With VEC_CACHE_SRAM_XBAR_PERF_CNT_EN: 3 ports hold reads to bank 0 for 10 cycles -> perf_conflict_cnt[0]=10 and other banks 0. Preload 16'hFFFE, then 5 conflict cycles -> holds at 16'hFFFF.
